// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/branch controller for the 8-bit CPU program counter.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_mode,
  input  logic [PC_W-1:0]  i_pc,
  output logic [PC_W-1:0]  o_pc_add,
  output logic             o_in_cmd,
  output logic             o_is_done,
  output logic             o_mem_req,
  input  logic             i_mem_ready,
  input  logic [7:0]       i_mem_data,
  input  logic             i_zero,
  input  logic             i_carry,
  output logic             o_exec,
  output logic [3:0]       o_op,
  output logic [3:0]       o_imm,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_TGT,
    S_HALT,
    S_LOAD
  } state_t;

  localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             taken;
  logic [3:0]       ir_op;

  assign ir_op     = ir_q[7:4];
  assign o_op      = ir_q[7:4];
  assign o_imm     = ir_q[3:0];
  assign o_retired = retired_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retire    = 1'b0;
    taken     = 1'b0;
    o_pc_add  = i_pc;
    o_mem_req = 1'b0;
    o_exec    = 1'b0;
    o_in_cmd  = 1'b0;
    o_is_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          ir_d     = i_mem_data;
          o_pc_add = i_pc + PC_W'(1);
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_op <= 4'hB) begin
          o_exec  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (ir_op == 4'hF) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH_TGT;
        end
      end
      S_FETCH_TGT: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          taken    = (ir_op == 4'hC) || (ir_op == 4'hD && i_zero) || (ir_op == 4'hE && i_carry);
          o_pc_add = taken ? PC_W'(i_mem_data) : i_pc + PC_W'(1);
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HALT: begin
        o_is_done = 1'b1;
      end
      S_LOAD: begin
        o_in_cmd = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Program loading wins over everything: abandon any fetch and freeze the PC this cycle.
    if (i_load_mode) begin
      state_d   = S_LOAD;
      ir_d      = ir_q;
      retire    = 1'b0;
      o_exec    = 1'b0;
      o_mem_req = 1'b0;
      o_pc_add  = i_pc;
    end

    if (rst) begin
      o_pc_add = i_pc;
    end

    retired_d = (retire && retired_q != RET_MAX) ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with an instruction-level reference model.
module tb_pc_sequencer;
  localparam int PC_W  = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_load_mode;
  logic [PC_W-1:0]  i_pc;
  logic [PC_W-1:0]  o_pc_add;
  logic             o_in_cmd;
  logic             o_is_done;
  logic             o_mem_req;
  logic             i_mem_ready;
  logic [7:0]       i_mem_data;
  logic             i_zero;
  logic             i_carry;
  logic             o_exec;
  logic [3:0]       o_op;
  logic [3:0]       o_imm;
  logic [CNT_W-1:0] o_retired;

  pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_load_mode(i_load_mode), .i_pc(i_pc), .o_pc_add(o_pc_add),
    .o_in_cmd(o_in_cmd), .o_is_done(o_is_done), .o_mem_req(o_mem_req), .i_mem_ready(i_mem_ready),
    .i_mem_data(i_mem_data), .i_zero(i_zero), .i_carry(i_carry), .o_exec(o_exec), .o_op(o_op),
    .o_imm(o_imm), .o_retired(o_retired)
  );

  always #5 clk = ~clk;

  // PC register and program memory surrounding the sequencer
  logic [7:0] pc_reg;
  logic [7:0] mem [256];
  assign i_pc       = pc_reg;
  assign i_mem_data = mem[i_pc];

  always @(posedge clk or posedge rst) begin
    if (rst)             pc_reg <= 8'h00;
    else if (o_in_cmd)   pc_reg <= 8'h00;
    else if (!o_is_done) pc_reg <= o_pc_add;
  end

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_op[$];
  logic [3:0] exp_imm[$];
  logic [7:0] exp_pc;
  int         exp_ret;
  bit         exp_halt;

  // Instruction-level interpreter: runs up to max_n instructions from address 0.
  task automatic model_run(input int max_n, input logic z, input logic c);
    logic [7:0] pc;
    logic [7:0] b;
    logic [7:0] t;
    exp_op.delete();
    exp_imm.delete();
    pc = 8'h00;
    exp_ret = 0;
    exp_halt = 0;
    while (exp_ret < max_n && !exp_halt) begin
      b  = mem[pc];
      pc = pc + 8'h01;
      if (b[7:4] <= 4'hB) begin
        exp_op.push_back(b[7:4]);
        exp_imm.push_back(b[3:0]);
      end else if (b[7:4] == 4'hF) begin
        exp_halt = 1;
      end else begin
        t  = mem[pc];
        pc = pc + 8'h01;
        if (b[7:4] == 4'hC || (b[7:4] == 4'hD && z) || (b[7:4] == 4'hE && c)) pc = t;
      end
      exp_ret++;
    end
    exp_pc = pc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    i_load_mode = 0;
    i_mem_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Runs the DUT until it has retired exp_ret instructions, comparing every exec strobe on the way.
  task automatic run_program(input string name, input int budget, input bit rdy_rand);
    bit done;
    logic [3:0] e_op;
    logic [3:0] e_imm;
    done = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      i_mem_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (o_exec) begin
        checks++;
        if (exp_op.size() == 0) begin
          errors++;
          $display("FAIL %s extra_exec got op=%0h imm=%0h required no strobe", name, o_op, o_imm);
        end else begin
          e_op  = exp_op.pop_front();
          e_imm = exp_imm.pop_front();
          if ({o_op, o_imm} !== {e_op, e_imm}) begin
            errors++;
            $display("FAIL %s exec_fields got %0h/%0h required %0h/%0h", name, o_op, o_imm, e_op, e_imm);
          end
        end
      end
      @(posedge clk);
      #1;
      if (o_retired == CNT_W'(exp_ret)) done = 1;
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout retired=%0d required %0d", name, o_retired, exp_ret);
    end else begin
      checks++;
      if (i_pc !== exp_pc) begin
        errors++;
        $display("FAIL %s final_pc got %0h required %0h", name, i_pc, exp_pc);
      end
      checks++;
      if (o_is_done !== exp_halt) begin
        errors++;
        $display("FAIL %s halted got %0b required %0b", name, o_is_done, exp_halt);
      end
      checks++;
      if (exp_op.size() != 0) begin
        errors++;
        $display("FAIL %s missing_exec got %0d pending required 0", name, exp_op.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    i_load_mode = 0;
    i_mem_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_pc_add !== i_pc)   begin errors++; $display("FAIL reset_pc_add got %0h required %0h", o_pc_add, i_pc); end
    checks++; if (o_mem_req !== 1'b1)  begin errors++; $display("FAIL reset_mem_req got %0b required 1", o_mem_req); end
    checks++; if (o_exec !== 1'b0)     begin errors++; $display("FAIL reset_exec got %0b required 0", o_exec); end
    checks++; if (o_in_cmd !== 1'b0)   begin errors++; $display("FAIL reset_in_cmd got %0b required 0", o_in_cmd); end
    checks++; if (o_is_done !== 1'b0)  begin errors++; $display("FAIL reset_is_done got %0b required 0", o_is_done); end
    checks++; if (o_retired !== 8'd0)  begin errors++; $display("FAIL reset_retired got %0d required 0", o_retired); end
    checks++; if ({o_op, o_imm} !== 8'h00) begin errors++; $display("FAIL reset_op_imm got %0h%0h required 00", o_op, o_imm); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_program();
    do_reset();
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hF0;
    model_run(10, 1'b0, 1'b0);
    run_program("program", 100, 0);
    checks++; if (i_pc !== 8'd3)      begin errors++; $display("FAIL program_pc got %0h required 3", i_pc); end
    checks++; if (o_retired !== 8'd3) begin errors++; $display("FAIL program_retired got %0d required 3", o_retired); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (i_pc !== 8'd3 || o_is_done !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL halt_hold got pc=%0h done=%0b req=%0b required pc=3 done=1 req=0", i_pc, o_is_done, o_mem_req);
    end
  endtask

  task automatic test_jmp();
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h10; mem[8'h10] = 8'h15;
    i_mem_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (o_exec !== 1'b0) begin errors++; $display("FAIL jmp_no_exec cycle %0d got %0b required 0", k, o_exec); end
      @(negedge clk);
    end
    #1;
    checks++; if (o_pc_add !== 8'h10) begin errors++; $display("FAIL jmp_target got %0h required 10", o_pc_add); end
    checks++; if (o_exec !== 1'b0)    begin errors++; $display("FAIL jmp_tgt_exec got %0b required 0", o_exec); end
    @(negedge clk);
    #1;
    checks++; if (i_pc !== 8'h10 || o_mem_req !== 1'b1) begin
      errors++; $display("FAIL jmp_next_fetch got pc=%0h req=%0b required pc=10 req=1", i_pc, o_mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_cond_branch();
    logic [3:0] op;
    bit flag;
    logic [7:0] want;
    for (int k = 0; k < 4; k++) begin
      op   = (k < 2) ? 4'hD : 4'hE;
      flag = (k % 2) == 1;
      want = flag ? 8'h80 : 8'h06;
      do_reset();
      clear_mem();
      mem[4] = {op, 4'h0};
      mem[5] = 8'h80;
      i_zero  = (op == 4'hD) ? flag : !flag;
      i_carry = (op == 4'hE) ? flag : !flag;
      model_run(5, i_zero, i_carry);
      run_program(op == 4'hD ? "jz" : "jc", 200, 1);
      checks++; if (i_pc !== want) begin errors++; $display("FAIL cond_branch op=%0h flag=%0b got %0h required %0h", op, flag, i_pc, want); end
    end
    i_zero = 0;
    i_carry = 0;
  endtask

  task automatic test_wait_states();
    do_reset();
    clear_mem();
    mem[0] = 8'h15;
    for (int k = 0; k < 3; k++) begin
      i_mem_ready = 0;
      #1;
      checks++; if (o_mem_req !== 1'b1 || o_pc_add !== i_pc || i_pc !== 8'h00) begin
        errors++; $display("FAIL wait_hold cycle %0d got req=%0b add=%0h pc=%0h required req=1 add=pc pc=0", k, o_mem_req, o_pc_add, i_pc);
      end
      @(negedge clk);
    end
    i_mem_ready = 1;
    #1;
    checks++; if (o_pc_add !== 8'h01) begin errors++; $display("FAIL wait_ready_add got %0h required 1", o_pc_add); end
    @(negedge clk);
    i_mem_ready = 0;
    #1;
    checks++; if (i_pc !== 8'h01 || o_exec !== 1'b1 || o_op !== 4'h1 || o_imm !== 4'h5) begin
      errors++; $display("FAIL wait_exec got pc=%0h exec=%0b op=%0h imm=%0h required pc=1 exec=1 op=1 imm=5", i_pc, o_exec, o_op, o_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_load_abort();
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h44;
    i_mem_ready = 1;
    @(negedge clk);
    i_mem_ready = 0;
    @(negedge clk);
    #1;
    checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL load_tgt_req got %0b required 1", o_mem_req); end
    @(negedge clk);
    i_load_mode = 1;
    i_mem_ready = 1;
    #1;
    checks++; if (o_pc_add !== i_pc || o_exec !== 1'b0) begin
      errors++; $display("FAIL load_entry got add=%0h exec=%0b required add=%0h exec=0", o_pc_add, o_exec, i_pc);
    end
    @(negedge clk);
    #1;
    checks++; if (o_in_cmd !== 1'b1 || o_retired !== 8'd0 || i_pc !== 8'h01) begin
      errors++; $display("FAIL load_state got in_cmd=%0b retired=%0d pc=%0h required 1/0/01", o_in_cmd, o_retired, i_pc);
    end
    @(negedge clk);
    i_load_mode = 0;
    i_mem_ready = 0;
    #1;
    checks++; if (i_pc !== 8'h00 || o_in_cmd !== 1'b1) begin
      errors++; $display("FAIL load_clear got pc=%0h in_cmd=%0b required pc=0 in_cmd=1", i_pc, o_in_cmd);
    end
    @(negedge clk);
    i_mem_ready = 1;
    #1;
    checks++; if (o_in_cmd !== 1'b0 || o_mem_req !== 1'b1 || i_pc !== 8'h00 || o_pc_add !== 8'h01) begin
      errors++; $display("FAIL load_restart got in_cmd=%0b req=%0b pc=%0h add=%0h required 0/1/00/01", o_in_cmd, o_mem_req, i_pc, o_pc_add);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h44;
    i_mem_ready = 1;
    @(negedge clk);
    i_mem_ready = 0;
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (i_pc !== 8'h00 || o_pc_add !== 8'h00) begin
      errors++; $display("FAIL async_rst got pc=%0h add=%0h required 0/0", i_pc, o_pc_add);
    end
    @(negedge clk);
    rst = 0;
    i_mem_ready = 1;
    #1;
    checks++; if (o_pc_add !== 8'h01) begin errors++; $display("FAIL async_rst_fetch got add=%0h required 01", o_pc_add); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h37;
    model_run(1, 1'b0, 1'b0);
    run_program("wrap_jmp", 50, 0);
    i_mem_ready = 1;
    #1;
    checks++; if (o_pc_add !== 8'h00) begin errors++; $display("FAIL wrap_add got %0h required 00", o_pc_add); end
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'hFE; mem[8'hFE] = 8'h21; mem[8'hFF] = 8'hC5;
    model_run(3, 1'b0, 1'b0);
    run_program("wrap_two_byte", 80, 1);
    checks++; if (i_pc !== 8'hC0) begin errors++; $display("FAIL wrap_operand got %0h required C0", i_pc); end
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    clear_mem();
    i_mem_ready = 1;
    n = 0;
    for (int cyc = 0; cyc < 1000 && n < 260; cyc++) begin
      #1;
      if (o_exec) begin
        n++;
        if (n == 255 || n == 257) begin
          checks++;
          if (o_retired !== CNT_W'(n - 1 > 255 ? 255 : n - 1)) begin
            errors++; $display("FAIL sat_progress exec %0d got %0d required %0d", n, o_retired, (n - 1 > 255 ? 255 : n - 1));
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (n != 260) begin errors++; $display("FAIL sat_count got %0d execs required 260", n); end
    checks++; if (o_retired !== 8'd255) begin errors++; $display("FAIL sat_retired got %0d required 255", o_retired); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      i_zero  = 1'($urandom);
      i_carry = 1'($urandom);
      model_run($urandom_range(5, 40), i_zero, i_carry);
      run_program("random", 800, 1);
    end
  endtask

  initial begin
    rst = 1;
    i_load_mode = 0;
    i_mem_ready = 0;
    i_zero = 0;
    i_carry = 0;
    clear_mem();
    test_reset();
    test_program();
    test_jmp();
    test_cond_branch();
    test_wait_states();
    test_load_abort();
    test_async_reset();
    test_wrap();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/branch controller that sequences the program counter register and instruction memory of the 8-bit CPU.
- Drives the PC register's next-value, hold and clear inputs.
- Runs the program-memory request handshake and issues one-cycle execute strobes to the ALU/register datapath.
- Resolves JMP/JZ/JC/HLT itself, so the datapath never touches the PC.

Parameters:
PC_W, 8, program counter and memory address width; PC arithmetic is modulo 2^PC_W.
CNT_W, 8, width of the retired-instruction counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
i_load_mode  input  1  high while the host loads program memory.
i_pc  input  PC_W  current value of the PC register.
o_pc_add  output  PC_W  next-PC value presented to the PC register.
o_in_cmd  output  1  clears the PC register (program-load mode).
o_is_done  output  1  holds the PC register (halted).
o_mem_req  output  1  instruction-memory read request; address is i_pc.
i_mem_ready  input  1  memory has valid data this cycle for the pending request.
i_mem_data  input  8  instruction/operand byte.
i_zero  input  1  registered datapath zero flag.
i_carry  input  1  registered datapath carry flag.
o_exec  output  1  one-cycle execute strobe to the datapath.
o_op  output  4  opcode of the instruction being executed.
o_imm  output  4  4-bit immediate of the instruction being executed.
o_retired  output  CNT_W  retired-instruction count, saturating.

Behaviour:
- Encoding: byte[7:4] = op, byte[3:0] = imm.
  - op 0x0–0xB: single-byte datapath ops.
  - op 0xC JMP, 0xD JZ, 0xE JC: two-byte; the second byte is the absolute target.
  - op 0xF: HLT.
- States: FETCH, DECODE, FETCH_TGT, HALT, LOAD. Reset state is FETCH.
- Registered values and their reset values: state = FETCH, IR = 0, o_op = 0, o_imm = 0, o_retired = 0.
- Combinational outputs and their values while in reset: o_pc_add = i_pc, o_mem_req = 1 (FETCH), o_exec = 0, o_in_cmd = 0, o_is_done = 0.
- Default o_pc_add = i_pc (hold), except in the cases listed below.
- FETCH:
  - o_mem_req = 1.
  - Stays in FETCH until i_mem_ready.
  - On the ready cycle: IR <= i_mem_data, o_pc_add = i_pc + 1, next state DECODE.
- DECODE:
  - op <= 0xB: o_exec = 1 for this cycle only, with o_op/o_imm = IR fields (o_op/o_imm registered from IR on FETCH completion). o_retired increments. Next state FETCH.
  - op 0xC–0xE: next state FETCH_TGT.
  - op 0xF: o_retired increments; next state HALT.
- FETCH_TGT:
  - o_mem_req = 1; waits for i_mem_ready.
  - On the ready cycle, taken = JMP | (JZ & i_zero) | (JC & i_carry).
  - Taken: o_pc_add = i_mem_data. Not taken: o_pc_add = i_pc + 1.
  - o_retired increments; next state FETCH.
  - Flags are sampled on this ready cycle. Flags from the preceding exec are valid here because at least one FETCH cycle separates them.
- HALT:
  - o_is_done = 1, o_mem_req = 0, o_pc_add = i_pc.
  - Exits only via i_load_mode or rst.
- LOAD:
  - o_in_cmd = 1, o_mem_req = 0.
  - Stays while i_load_mode = 1; when it falls, next state FETCH, so execution restarts at PC 0.
- i_load_mode = 1 in any state takes priority over everything else:
  - Next state LOAD.
  - In that cycle: o_exec = 0, no retire increment, o_pc_add = i_pc, and any IR/target latch is suppressed.
  - A pending memory request is abandoned; a late i_mem_ready is ignored.
- i_mem_ready while o_mem_req = 0 is ignored.
- Wrap-around: i_pc = 0xFF advancing gives o_pc_add = 0x00. The same wrap applies for a two-byte instruction at 0xFF, whose operand is fetched from 0x00.
- o_retired saturates at 2^CNT_W − 1 and clears only on rst.
- Async rst mid-operation: state returns to FETCH immediately, and an in-flight handshake is dropped.
- Throughput with zero-wait memory: single-byte op takes 2 cycles, branch 3 cycles, HLT 2 cycles to HALT.

Test Plan:
- Reset, memory always ready, program {0x15, 0x23, 0xF0} at 0..2 → o_exec pulses with op/imm (1,5) then (2,3); o_is_done = 1 with PC held at 3; o_retired = 3.
- JMP: 0xC0 0x10 at address 0 → after the target ready cycle o_pc_add = 0x10; next fetch is at 0x10; no o_exec pulse.
- JZ with i_zero = 0 at address 4 → PC goes to 6 (not taken). Repeat with i_zero = 1, target 0x80 → PC = 0x80. Same pair of checks for JC using i_carry.
- i_mem_ready delayed 3 cycles in FETCH → o_mem_req held high; o_pc_add = i_pc every wait cycle; PC unchanged until ready.
- Raise i_load_mode during the FETCH_TGT wait, then assert a late i_mem_ready → next cycle o_in_cmd = 1 and the PC is cleared; the late ready is ignored. Drop i_load_mode → fetch restarts from 0.
- PC = 0xFF with a single-byte op → o_pc_add = 0x00. Execute 260 instructions → o_retired saturates at 255.
